// File: rtl/hazard_scoreboard_if.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_if
//   Bundle between the ID stage of the pipelined core and the hazard
//   scoreboard.
//
//   ID -> scoreboard : id_valid, id_src, id_waddr, id_regwrite, id_memread,
//                      flush, hold
//   scoreboard -> ID : stall, ex_fwd_sel, id_bypass
//
//   master : the core side (drives the ID instruction and pipeline controls)
//   slave  : the scoreboard
// ---------------------------------------------------------------------------
interface hazard_scoreboard_if #(
    parameter int NSRC    = 2,
    parameter int REGBITS = 5,
    parameter int NSTAGES = 3
);
    localparam int SELW = $clog2(NSTAGES + 1);

    logic                    id_valid;
    logic [NSRC*REGBITS-1:0] id_src;
    logic [REGBITS-1:0]      id_waddr;
    logic                    id_regwrite;
    logic                    id_memread;
    logic                    flush;
    logic                    hold;
    logic                    stall;
    logic [NSRC*SELW-1:0]    ex_fwd_sel;
    logic [NSRC-1:0]         id_bypass;

    modport master (
        output id_valid, id_src, id_waddr, id_regwrite, id_memread, flush, hold,
        input  stall, ex_fwd_sel, id_bypass
    );

    modport slave (
        input  id_valid, id_src, id_waddr, id_regwrite, id_memread, flush, hold,
        output stall, ex_fwd_sel, id_bypass
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//   Shadow of the post-ID pipeline (destination, writer flag, load flag per
//   stage) used to derive load-use stalls, EX operand forward selects and ID
//   regfile bypasses for the pipelined MIPS core.
//
//   Ports:
//     clk    : clock, all state updates on the rising edge
//     reset  : asynchronous, active-low; clears every stage entry
//     hz     : hazard_scoreboard_if.slave
//              in : id_valid, id_src, id_waddr, id_regwrite, id_memread,
//                   flush, hold
//              out: stall, ex_fwd_sel, id_bypass (all combinational)
//
//   Stage 1 is EX, stage NSTAGES is the regfile write stage.
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int NSTAGES    = 3,
    parameter int NSRC       = 2,
    parameter int REGBITS    = 5,
    parameter int LOAD_READY = 3
) (
    input  logic               clk,
    input  logic               reset,
    hazard_scoreboard_if.slave hz
);
    localparam int SELW = $clog2(NSTAGES + 1);

    // Per-stage entries; index s is the pipeline stage (1 = EX)
    logic [NSTAGES:1]              valid_q, valid_d;
    logic [NSTAGES:1]              load_q,  load_d;
    logic [NSTAGES:1][REGBITS-1:0] waddr_q, waddr_d;
    // Source operands of the instruction currently in EX
    logic [NSRC-1:0][REGBITS-1:0]  src_q,   src_d;

    logic                          stall_raw;
    logic                          stall_c;
    logic                          take;
    logic [NSRC-1:0][SELW-1:0]     fwd_c;
    logic [NSRC-1:0]               byp_c;
    logic [REGBITS-1:0]            id_rd;
    int                            ym;
    logic                          ym_load;

    // Hazard detection: every search runs oldest-to-youngest so the youngest
    // (lowest-numbered) matching stage is the one left in the result.
    always_comb begin
        stall_raw = 1'b0;
        fwd_c     = '0;
        byp_c     = '0;
        id_rd     = '0;
        ym        = 0;
        ym_load   = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            id_rd   = hz.id_src[i*REGBITS +: REGBITS];
            ym      = 0;
            ym_load = 1'b0;
            for (int s = NSTAGES - 1; s >= 1; s--) begin
                if (id_rd != '0 && valid_q[s] && waddr_q[s] == id_rd) begin
                    ym      = s;
                    ym_load = load_q[s];
                end
            end
            // A load at stage s is one advance away from s+1 when the
            // consumer reaches EX; it must already be forwardable there.
            if (ym != 0 && ym_load && (ym + 1) < LOAD_READY) begin
                stall_raw = 1'b1;
            end
            // Bypass only when the write stage is the youngest producer.
            if (hz.id_valid && ym == 0 && id_rd != '0 &&
                valid_q[NSTAGES] && waddr_q[NSTAGES] == id_rd) begin
                byp_c[i] = 1'b1;
            end
            for (int s = NSTAGES; s >= 2; s--) begin
                if (src_q[i] != '0 && valid_q[s] && waddr_q[s] == src_q[i]) begin
                    fwd_c[i] = SELW'(s);
                end
            end
        end
        stall_c = stall_raw & hz.id_valid & ~hz.flush & ~hz.hold;
    end

    // Next state: shift toward the write stage, insert the ID instruction
    // or a bubble at EX. A bubble carries zero sources so it never forwards.
    always_comb begin
        take    = hz.id_valid & ~stall_c & ~hz.flush;
        valid_d = valid_q;
        load_d  = load_q;
        waddr_d = waddr_q;
        for (int s = NSTAGES; s >= 2; s--) begin
            valid_d[s] = valid_q[s-1];
            load_d[s]  = load_q[s-1];
            waddr_d[s] = waddr_q[s-1];
        end
        valid_d[1] = take & hz.id_regwrite;
        load_d[1]  = take & hz.id_memread;
        waddr_d[1] = take ? hz.id_waddr : '0;
        src_d      = take ? hz.id_src   : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            load_q  <= '0;
            waddr_q <= '0;
            src_q   <= '0;
        end else if (!hz.hold) begin
            valid_q <= valid_d;
            load_q  <= load_d;
            waddr_q <= waddr_d;
            src_q   <= src_d;
        end
    end

    assign hz.stall      = stall_c;
    assign hz.ex_fwd_sel = fwd_c;
    assign hz.id_bypass  = byp_c;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two instances (default depth, and
// NSTAGES=4/LOAD_READY=4) share one ID stimulus stream and are compared
// every cycle against an instruction-history model.
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       id_valid, id_regwrite, id_memread, flush, hold;
    logic [4:0] id_waddr, src0, src1;

    hazard_scoreboard_if #(.NSRC(2), .REGBITS(5), .NSTAGES(3)) ifa ();
    hazard_scoreboard_if #(.NSRC(2), .REGBITS(5), .NSTAGES(4)) ifb ();

    assign ifa.id_valid    = id_valid;
    assign ifa.id_src      = {src1, src0};
    assign ifa.id_waddr    = id_waddr;
    assign ifa.id_regwrite = id_regwrite;
    assign ifa.id_memread  = id_memread;
    assign ifa.flush       = flush;
    assign ifa.hold        = hold;
    assign ifb.id_valid    = id_valid;
    assign ifb.id_src      = {src1, src0};
    assign ifb.id_waddr    = id_waddr;
    assign ifb.id_regwrite = id_regwrite;
    assign ifb.id_memread  = id_memread;
    assign ifb.flush       = flush;
    assign ifb.hold        = hold;

    hazard_scoreboard #(.NSTAGES(3), .NSRC(2), .REGBITS(5), .LOAD_READY(3))
        dut_a (.clk(clk), .reset(reset), .hz(ifa));
    hazard_scoreboard #(.NSTAGES(4), .NSRC(2), .REGBITS(5), .LOAD_READY(4))
        dut_b (.clk(clk), .reset(reset), .hz(ifb));

    // Model: history of instructions that entered EX; element s is the
    // instruction that entered s advances ago (1 = currently in EX).
    typedef struct packed {
        logic       v;
        logic       ld;
        logic [4:0] wa;
        logic [4:0] s1;
        logic [4:0] s0;
    } ent_t;
    typedef ent_t [7:1] pipe_t;

    pipe_t pa, pb, pa_n, pb_n;
    int checks, errs;

    function automatic int yng(pipe_t p, int lo, int hi, logic [4:0] r);
        for (int s = lo; s <= hi; s++)
            if (r != 5'd0 && p[s].v && p[s].wa == r) return s;
        return 0;
    endfunction

    function automatic logic m_stall(pipe_t p, int nst, int lr);
        int s;
        if (!id_valid || flush || hold) return 1'b0;
        s = yng(p, 1, nst - 1, src0);
        if (s != 0 && p[s].ld && s + 1 < lr) return 1'b1;
        s = yng(p, 1, nst - 1, src1);
        if (s != 0 && p[s].ld && s + 1 < lr) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_fwd(pipe_t p, int nst);
        int selw;
        selw = $clog2(nst + 1);
        return 32'(yng(p, 2, nst, p[1].s0)) | (32'(yng(p, 2, nst, p[1].s1)) << selw);
    endfunction

    function automatic logic [31:0] m_byp(pipe_t p, int nst);
        logic [31:0] r;
        r = '0;
        if (id_valid) begin
            if (yng(p, 1, nst, src0) == nst) r[0] = 1'b1;
            if (yng(p, 1, nst, src1) == nst) r[1] = 1'b1;
        end
        return r;
    endfunction

    function automatic pipe_t m_adv(pipe_t p, int nst, logic st);
        pipe_t q;
        q = p;
        if (hold) return p;
        for (int s = nst; s >= 2; s--) q[s] = p[s-1];
        if (id_valid && !st && !flush) begin
            q[1].v  = id_regwrite;
            q[1].ld = id_memread;
            q[1].wa = id_waddr;
            q[1].s0 = src0;
            q[1].s1 = src1;
        end else begin
            q[1] = '0;
        end
        return q;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_id(logic v, logic rw, logic mr, logic [4:0] wa,
                          logic [4:0] a, logic [4:0] b);
        id_valid = v; id_regwrite = rw; id_memread = mr;
        id_waddr = wa; src0 = a; src1 = b;
    endtask

    task automatic nop();
        set_id(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    endtask

    // Settle after the input change, compare both instances with the model.
    task automatic look();
        logic sa, sb;
        #1;
        sa = m_stall(pa, 3, 3);
        sb = m_stall(pb, 4, 4);
        chk("A.stall", 32'(ifa.stall), 32'(sa));
        chk("A.fwd", 32'(ifa.ex_fwd_sel), m_fwd(pa, 3));
        chk("A.byp", 32'(ifa.id_bypass), m_byp(pa, 3));
        chk("B.stall", 32'(ifb.stall), 32'(sb));
        chk("B.fwd", 32'(ifb.ex_fwd_sel), m_fwd(pb, 4));
        chk("B.byp", 32'(ifb.id_bypass), m_byp(pb, 4));
        pa_n = m_adv(pa, 3, sa);
        pb_n = m_adv(pb, 4, sb);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            pa = pa_n; pb = pb_n;
        end else begin
            pa = '0; pb = '0;
        end
        @(negedge clk);
    endtask

    task automatic cyc();
        look();
        tick();
    endtask

    task automatic drain();
        nop();
        repeat (5) cyc();
    endtask

    // lw $8 then add $9,$8,$8 held in ID while the focused instance stalls
    task automatic pair(int focus, int exp_stalls, logic [31:0] exp_fwd, string tag);
        int   n, guard;
        logic st;
        n = 0; guard = 0;
        set_id(1'b1, 1'b1, 1'b1, 5'd8, 5'd1, 5'd0);
        cyc();
        set_id(1'b1, 1'b1, 1'b0, 5'd9, 5'd8, 5'd8);
        do begin
            look();
            st = (focus == 0) ? ifa.stall : ifb.stall;
            if (st) n++;
            tick();
            guard++;
        end while (st && guard < 10);
        nop();
        look();
        chk({tag, ".exfwd"}, (focus == 0) ? 32'(ifa.ex_fwd_sel) : 32'(ifb.ex_fwd_sel), exp_fwd);
        chk({tag, ".nstall"}, 32'(n), 32'(exp_stalls));
        tick();
    endtask

    initial begin
        checks = 0; errs = 0;
        reset = 1'b0; flush = 1'b0; hold = 1'b0;
        pa = '0; pb = '0;
        set_id(1'b1, 1'b1, 1'b1, 5'd8, 5'd8, 5'd8);
        #2;
        chk("rst.A.stall", 32'(ifa.stall), 32'd0);
        chk("rst.A.fwd", 32'(ifa.ex_fwd_sel), 32'd0);
        chk("rst.A.byp", 32'(ifa.id_bypass), 32'd0);
        chk("rst.B.fwd", 32'(ifb.ex_fwd_sel), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        drain();

        // Load-use, default depth: one stall, forward from stage 3 on both
        pair(0, 1, 32'd15, "s1");
        drain();
        // Deeper load: two stalls, forward from stage 4 on both
        pair(1, 2, 32'd36, "s2");
        drain();

        // ALU producer directly ahead: no stall, forward from stage 2
        set_id(1'b1, 1'b1, 1'b0, 5'd8, 5'd1, 5'd2); cyc();
        set_id(1'b1, 1'b1, 1'b0, 5'd10, 5'd8, 5'd9); look();
        chk("alu.stall", 32'(ifa.stall), 32'd0);
        tick();
        nop(); look();
        chk("alu.A.fwd", 32'(ifa.ex_fwd_sel), 32'd2);
        chk("alu.B.fwd", 32'(ifb.ex_fwd_sel), 32'd2);
        tick();
        drain();
        set_id(1'b1, 1'b1, 1'b0, 5'd0, 5'd1, 5'd2); cyc();
        set_id(1'b1, 1'b1, 1'b0, 5'd10, 5'd0, 5'd9); cyc();
        nop(); look();
        chk("r0.fwd", 32'(ifa.ex_fwd_sel), 32'd0);
        tick();
        drain();

        // Two producers of $8: youngest (stage 2) wins
        set_id(1'b1, 1'b1, 1'b0, 5'd8, 5'd1, 5'd2); cyc();
        set_id(1'b1, 1'b1, 1'b0, 5'd8, 5'd3, 5'd4); cyc();
        set_id(1'b1, 1'b1, 1'b0, 5'd10, 5'd8, 5'd8); cyc();
        nop(); look();
        chk("young.fwd", 32'(ifa.ex_fwd_sel), 32'd10);
        tick();
        drain();

        // Only the write stage holds $8: ID bypass on operand 0
        set_id(1'b1, 1'b1, 1'b0, 5'd8, 5'd1, 5'd2); cyc();
        nop(); cyc();
        cyc();
        set_id(1'b1, 1'b1, 1'b0, 5'd11, 5'd8, 5'd5); look();
        chk("byp.A", 32'(ifa.id_bypass), 32'd1);
        tick();
        drain();

        // Flush beats stall; a bubble enters EX
        set_id(1'b1, 1'b1, 1'b1, 5'd8, 5'd1, 5'd0); cyc();
        set_id(1'b1, 1'b1, 1'b0, 5'd9, 5'd8, 5'd8);
        flush = 1'b1; look();
        chk("flush.A.stall", 32'(ifa.stall), 32'd0);
        chk("flush.B.stall", 32'(ifb.stall), 32'd0);
        tick();
        flush = 1'b0; nop(); look();
        chk("flush.bubble", 32'(ifa.ex_fwd_sel), 32'd0);
        tick();
        drain();

        // Hold for three cycles: forwarding state frozen
        set_id(1'b1, 1'b1, 1'b0, 5'd8, 5'd1, 5'd2); cyc();
        nop(); cyc();
        set_id(1'b1, 1'b1, 1'b0, 5'd10, 5'd8, 5'd8); cyc();
        set_id(1'b1, 1'b1, 1'b0, 5'd12, 5'd10, 5'd10);
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            look();
            chk("hold.fwd", 32'(ifa.ex_fwd_sel), 32'd15);
            chk("hold.stall", 32'(ifa.stall), 32'd0);
            tick();
        end
        hold = 1'b0; nop(); look();
        chk("hold.rel", 32'(ifa.ex_fwd_sel), 32'd15);
        tick();
        look();
        chk("hold.adv", 32'(ifa.ex_fwd_sel), 32'd0);
        tick();
        drain();

        // Reset in the middle of a load-use stall
        set_id(1'b1, 1'b1, 1'b1, 5'd8, 5'd1, 5'd0); cyc();
        set_id(1'b1, 1'b1, 1'b0, 5'd9, 5'd8, 5'd8); look();
        chk("mid.pre", 32'(ifa.stall), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid.stall", 32'(ifa.stall), 32'd0);
        chk("mid.B.stall", 32'(ifb.stall), 32'd0);
        pa = '0; pb = '0;
        tick();
        look();
        tick();
        reset = 1'b1;
        drain();
        pair(0, 1, 32'd15, "post");
        drain();

        // Random traffic on a small register set to provoke hazards
        for (int n = 0; n < 400; n++) begin
            set_id(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                   $urandom_range(0, 2) == 0, 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            flush = ($urandom_range(0, 7) == 0);
            hold  = ($urandom_range(0, 7) == 0);
            cyc();
        end
        flush = 1'b0; hold = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard unit for the pipelined MIPS core, replacing the fixed EX/MEM/WB forwarding and load-use logic. It keeps its own shadow of the post-ID pipeline (destination register, write/load flags per stage) and produces three things: ID stalls, EX operand forward selects and ID regfile bypasses. Depth, operand count and load latency are parameters, so deeper memory stages or extra source ports need no rewrite. It also provides a whole-pipeline hold mode for memory wait states.

## Interface
- NSTAGES, 3: stages after ID holding a writer; 1 = EX, NSTAGES = WB (regfile write stage); range 2..7
- NSRC, 2: source operands per instruction
- REGBITS, 5: register address width
- LOAD_READY, 3: first stage index at which a load result is forwardable; range 2..NSTAGES
- SELW, derived = $clog2(NSTAGES+1): forward-select field width
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- id_valid  in  1  ID holds a real instruction
- id_src  in  NSRC*REGBITS  ID source registers, operand i at [i*REGBITS +: REGBITS]
- id_waddr  in  REGBITS  ID destination register (after regdst/jal selection)
- id_regwrite  in  1  ID instruction writes regfile
- id_memread  in  1  ID instruction is a load
- flush  in  1  branch/jump taken in EX; ID instruction is killed
- hold  in  1  external freeze (memory wait); no stage advances
- stall  out  1  freeze PC and IF/ID, bubble into EX
- ex_fwd_sel  out  NSRC*SELW  per EX operand: 0 = own read value, s = forward from stage s (2..NSTAGES)
- id_bypass  out  NSRC  per ID operand: take stage-NSTAGES write data instead of regfile read

## Operation
- State: per stage s = 1..NSTAGES an entry {valid, waddr, load}. Stage 1 additionally holds the NSRC source addresses of the EX instruction.
- A match of register r at stage s means: entry valid, waddr == r, r != 0. "Youngest match" = the match with the lowest s. Only the youngest match is ever used.
- stall (combinational): asserted if, for any operand i, the youngest match of id_src[i] among stages 1..NSTAGES-1 is a load at stage s with s+1 < LOAD_READY. Gated by id_valid, and forced 0 when flush or hold is asserted.
- ex_fwd_sel[i]: youngest match of stage-1 src[i] among stages 2..NSTAGES, else 0. A load match at s < LOAD_READY cannot reach here if stall is correct.
- id_bypass[i]: asserted when stage NSTAGES matches id_src[i] and no younger stage 1..NSTAGES-1 matches it. Gated by id_valid.
- Advance (every clock edge where hold is 0):
  - Entries shift from s to s+1; the stage NSTAGES entry retires.
  - Stage 1 loads {id_valid & id_regwrite, id_waddr, id_memread, id_src} when id_valid & ~stall & ~flush; otherwise it loads a bubble (valid 0).
- hold = 1: all entries keep their value. stall, ex_fwd_sel and id_bypass are still computed from the held state.
- Entries with regwrite = 0 are stored invalid. Stores and branches therefore never create hazards.
- flush and stall in the same cycle: flush wins, stall = 0, bubble enters stage 1.

## Timing
- While reset is low: all entries invalid; stall = 0, ex_fwd_sel = 0, id_bypass = 0. Outputs are forced 0 regardless of inputs.
- Reset release: the first advance happens at the first rising edge with reset high and hold low.
- Outputs are purely combinational from state plus current ID inputs. There is no output register and no added pipeline latency.
- Load-use penalty = max(0, LOAD_READY - 2) stall cycles for a consumer directly behind a load. ALU results forward with 0 stalls.
- Register 0 never matches at any stage.
- Reset asserted mid-stall: state clears immediately and stall drops asynchronously.

## Test plan
- Defaults. Cycle 0: ID lw $8 (id_memread = 1). Cycle 1: ID add $9,$8,$8 -> stall = 1 in cycle 1 only. Cycle 3: add in EX -> ex_fwd_sel = {3,3}. Total 1 stall.
- NSTAGES = 4, LOAD_READY = 4, same sequence -> stall held for 2 consecutive cycles; EX forward select = 4.
- add $8 followed by sub $10,$8,$9 -> no stall; sub in EX has ex_fwd_sel[0] = 2, ex_fwd_sel[1] = 0. Destination $0 producer instead -> all selects 0.
- Producers in stage 3 ($8, ALU) and stage 2 ($8, ALU) both present -> EX consumer gets select 2 (youngest). Only stage 3 matching an ID read of $8 -> id_bypass[0] = 1.
- lw $8 in stage 1 with a dependent consumer in ID, flush = 1 -> stall = 0 and a bubble enters stage 1. hold = 1 for 3 cycles -> entries unchanged and ex_fwd_sel stable.
- reset pulled low while stall = 1 -> stall = 0 immediately. After release, a dependent pair behaves exactly as in scenario 1.
